// File: rtl/ddr3_pkg.sv
// Shared constants and types for the DDR3 frame writer.
//   DDR3_DATA_WIDTH  width of one DDR3 interface word
//   DDR3_WORD_BYTES  byte stride between consecutive word addresses
//   PIXELS_PER_WORD  pixels packed into one word
//   writer_state_e   hold-buffer / write-request FSM states
package ddr3_pkg;

  localparam int DDR3_DATA_WIDTH = 128;
  localparam int DDR3_WORD_BYTES = 16;
  localparam int PIXELS_PER_WORD = 16;
  localparam int PACK_CNT_WIDTH  = $clog2(PIXELS_PER_WORD);

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_BUSY = 1'b1
  } writer_state_e;

endpackage

// File: rtl/pixel_packer_128.sv
// Packs show-ahead FIFO pixels into 128-bit words.
//   clk, reset     clock, asynchronous active-low reset
//   in_dout        pixel from upstream FIFO (valid with in_rd_en)
//   in_empty       upstream FIFO empty
//   in_rd_en       pop request to upstream FIFO
//   word_valid     a complete word is handed off on this edge
//   word_ready     hold buffer can take a word on this edge
//   word_data      packed word; pixel k in bits [8k+7:8k]
// Lanes 0..14 are registered; lane 15 is taken straight from in_dout so the
// word hands off on the same edge as its 16th pop.
module pixel_packer_128
  import ddr3_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [PIXEL_WIDTH-1:0]                 in_dout,
  input  logic                                   in_empty,
  output logic                                   in_rd_en,
  output logic                                   word_valid,
  input  logic                                   word_ready,
  output logic [PIXEL_WIDTH*PIXELS_PER_WORD-1:0] word_data
);

  localparam int LOW_BITS = PIXEL_WIDTH * (PIXELS_PER_WORD - 1);
  localparam logic [PACK_CNT_WIDTH-1:0] LAST_LANE = PACK_CNT_WIDTH'(PIXELS_PER_WORD - 1);

  logic [PACK_CNT_WIDTH-1:0] pack_cnt;
  logic [LOW_BITS-1:0]       lanes;
  logic                      last_lane;

  assign last_lane = (pack_cnt == LAST_LANE);

  // The final pop of a word is withheld until the hold buffer can take it,
  // so a partially filled word is never handed off. No pops during reset.
  assign in_rd_en   = reset && !in_empty && !(last_lane && !word_ready);
  assign word_valid = in_rd_en && last_lane;
  assign word_data  = {in_dout, lanes};

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pack_cnt <= '0;
      // NOTE: the lane register is reset explicitly; stale pixels must
      // never be visible after reset.
      lanes    <= '0;
    end else if (in_rd_en) begin
      if (last_lane) begin
        pack_cnt <= '0;
      end else begin
        pack_cnt <= pack_cnt + 1'b1;
        for (int k = 0; k < PIXELS_PER_WORD - 1; k++) begin
          if (pack_cnt == PACK_CNT_WIDTH'(k)) begin
            lanes[k*PIXEL_WIDTH +: PIXEL_WIDTH] <= in_dout;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ddr3_frame_writer.sv
// Streams a frame of 8-bit pixels into DDR3 as single-beat 128-bit writes.
//   clk, reset        clock, asynchronous active-low reset
//   in_dout/in_empty  show-ahead upstream FIFO read side; in_rd_en pops
//   wr_en             write request, held until write_complete
//   sdram_address     byte address of the current word
//   write_data_input  current word; pixel k in bits [8k+7:8k]
//   write_complete    one-cycle acceptance pulse from the DDR3 interface
//   frame_done        one-cycle pulse after the last word of a frame
//   stall_cycles      back-pressure cycle counter, present only when
//                     DDR3_FRAME_WRITER_STALL_COUNT_EN is defined (else 0)
// The packer keeps filling the next word while the hold buffer (this FSM)
// owns the word in flight.
module ddr3_frame_writer
  import ddr3_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          FRAME_PIXELS = 307200,
  parameter int          PIXEL_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [PIXEL_WIDTH-1:0]     in_dout,
  input  logic                       in_empty,
  output logic                       in_rd_en,
  output logic                       wr_en,
  output logic [31:0]                sdram_address,
  output logic [DDR3_DATA_WIDTH-1:0] write_data_input,
  input  logic                       write_complete,
  output logic                       frame_done,
  output logic [31:0]                stall_cycles
);

  localparam int          FRAME_WORDS = FRAME_PIXELS / PIXELS_PER_WORD;
  localparam logic [31:0] LAST_WORD   = 32'(FRAME_WORDS - 1);
  localparam int          ADDR_SHIFT  = $clog2(DDR3_WORD_BYTES);

  writer_state_e              state;
  logic [31:0]                word_idx;
  logic [31:0]                next_idx;
  logic                       word_valid;
  logic                       word_ready;
  logic                       accept;
  logic                       wrap;
  logic [DDR3_DATA_WIDTH-1:0] word_data;

  assign accept = (state == W_BUSY) && write_complete;
  assign wrap   = accept && (word_idx == LAST_WORD);

  // Index the next word will use; a word loading on the completion edge
  // already takes the advanced address.
  assign next_idx = wrap ? '0 : (accept ? word_idx + 32'd1 : word_idx);

  // Hold buffer is free when idle or when its word is accepted this edge.
  assign word_ready = (state == W_IDLE) || write_complete;

  pixel_packer_128 #(
    .PIXEL_WIDTH (PIXEL_WIDTH)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .in_dout    (in_dout),
    .in_empty   (in_empty),
    .in_rd_en   (in_rd_en),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .word_data  (word_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= W_IDLE;
      word_idx         <= '0;
      sdram_address    <= BASE_ADDR;
      write_data_input <= '0;
      frame_done       <= 1'b0;
    end else begin
      word_idx   <= next_idx;
      frame_done <= wrap;
      if (word_valid) begin
        // Either from idle or back-to-back on the completion edge.
        write_data_input <= word_data;
        sdram_address    <= BASE_ADDR + (next_idx << ADDR_SHIFT);
        state            <= W_BUSY;
      end else if (accept) begin
        // Drop the request right away so a completed word is never re-issued.
        state <= W_IDLE;
      end
    end
  end

  assign wr_en = (state == W_BUSY);

`ifdef DDR3_FRAME_WRITER_STALL_COUNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (wrap) begin
      // Cleared on the edge that raises frame_done, so it reads 0 with it.
      stall_q <= '0;
    end else if (!in_empty && !in_rd_en && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule
